cksum_sched: RTL and testbench

Round-robin scheduler sharing the single `cksum` engine (and the `pkt_ram` read port behind it) between up to NUM_REQ checksum requesters: IPv4 header, L4 pseudo-header and payload, and reconfigurable-stage users. It latches one request at a time, sequences the engine's start/ready handshake, and returns the 16-bit result with a per-requester done pulse. A watchdog aborts engine runs that never complete.

---
 rtl/cksum_sched.sv | 141 ++++++++++++++
 tb/tb_cksum_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cksum_sched.sv
// cksum_sched: round-robin arbiter and start/ready sequencer in front of the shared cksum engine.
// Latency: grant one cycle after a request is seen in IDLE; done_o one cycle after engine ready.
// Backpressure: one job in flight; losing requesters hold req_i until their own done_o pulse.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module cksum_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0] req_len_i,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic [15:0]                    result_o,
  output logic [IDX_W-1:0]               grant_idx_o,
  output logic                           busy_o,
  output logic                           eng_start_o,
  output logic [`ADDR_WIDTH-1:0]         eng_addr_o,
  output logic [`DATA_WIDTH-1:0]         eng_len_o,
  input  logic                           eng_ready_i,
  input  logic [15:0]                    eng_val_i
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [15:0]        r_cnt;

  logic               w_hi_any;
  logic [IDX_W-1:0]   w_hi_win;
  logic               w_lo_any;
  logic [IDX_W-1:0]   w_lo_win;
  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_len;
  logic [NUM_REQ-1:0] w_done_vec;

  // Round-robin pick: lowest set bit above the pointer, else lowest set bit at or below it.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_win = '0;
    w_lo_any = 1'b0;
    w_lo_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i > int'(r_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_win = IDX_W'(i);
        end else begin
          w_lo_any = 1'b1;
          w_lo_win = IDX_W'(i);
        end
      end
    end
    w_any  = w_hi_any | w_lo_any;
    w_win  = w_hi_any ? w_hi_win : w_lo_win;
    w_addr = req_addr_i[w_win*AW +: AW];
    w_len  = req_len_i[w_win*DW +: DW];
  end

  assign w_done_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_o;

  // Job FSM; every output is a register so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      result_o    <= '0;
      grant_idx_o <= '0;
      busy_o      <= 1'b0;
      eng_start_o <= 1'b0;
      eng_addr_o  <= '0;
      eng_len_o   <= '0;
    end else begin
      done_o <= '0;
      err_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant_idx_o <= w_win;
            r_ptr       <= w_win;
            eng_addr_o  <= w_addr;
            eng_len_o   <= w_len;
            // A zero-length job passes through BUSY once without ever starting the engine.
            eng_start_o <= (w_len != '0);
            busy_o      <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 16'd1;
          if (eng_len_o == '0) begin
            result_o <= 16'hFFFF;
            done_o   <= w_done_vec;
            r_state  <= S_DONE;
          end else if ((r_cnt != 16'd0) && eng_ready_i) begin
            // Ready in the first BUSY cycle may be left over from the previous job.
            result_o    <= eng_val_i;
            done_o      <= w_done_vec;
            eng_start_o <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_cnt == 16'(TIMEOUT)) begin
            result_o    <= 16'h0000;
            err_o       <= 1'b1;
            done_o      <= w_done_vec;
            eng_start_o <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy_o      <= 1'b0;
          eng_start_o <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cksum_sched.sv
// Bench for cksum_sched: directed jobs against a small engine model.
// Expected completions are queued by the stimulus and consumed by an independent monitor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_cksum_sched;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 15;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_len_i;
  logic [NR-1:0]    done_o;
  logic             err_o;
  logic [15:0]      result_o;
  logic [IW-1:0]    grant_idx_o;
  logic             busy_o;
  logic             eng_start_o;
  logic [AW-1:0]    eng_addr_o;
  logic [DW-1:0]    eng_len_o;
  logic             eng_ready_i;
  logic [15:0]      eng_val_i;

  cksum_sched #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .done_o(done_o), .err_o(err_o), .result_o(result_o), .grant_idx_o(grant_idx_o),
    .busy_o(busy_o), .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o), .eng_len_o(eng_len_o),
    .eng_ready_i(eng_ready_i), .eng_val_i(eng_val_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] len;
    logic [15:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total;
  int   bad;
  int   eng_lat;
  bit   eng_hang;
  bit   eng_stale;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] l);
    req_addr_i[k*AW +: AW] = a;
    req_len_i[k*DW +: DW]  = l;
  endtask

  task automatic push_exp(input int idx, input int a, input int l, input logic [15:0] res,
                          input logic err, input int cyc);
    exp_t e;
    e.idx = idx; e.addr = a; e.len = l; e.res = res; e.err = err; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Raise the requested bits and drop each one as its done_o is seen, within a cycle budget.
  task automatic run_jobs(input logic [NR-1:0] mask);
    int n;
    n = 0;
    req_i = mask;
    while (req_i != '0 && n < 400) begin
      @(negedge clk);
      req_i = req_i & ~done_o;
      n++;
    end
    if (req_i != '0) begin
      total++;
      bad++;
      $display("FAIL run_jobs_budget: pending %b want 0", req_i);
      req_i = '0;
    end
  endtask

  function automatic logic [15:0] val_of(input logic [AW-1:0] a);
    case (a)
      16'd14:  val_of = 16'hB1E6;
      16'd100: val_of = 16'h1234;
      16'd200: val_of = 16'hBEEF;
      16'd300: val_of = 16'h0F0F;
      16'd400: val_of = 16'hCAFE;
      16'd500: val_of = 16'h5A5A;
      16'd700: val_of = 16'h1357;
      16'd800: val_of = 16'h2468;
      default: val_of = 16'hDEAD;
    endcase
  endfunction

  // Engine model: ready for one cycle eng_lat cycles after start rises; optional stale ready.
  initial begin
    int  cnt;
    bit  prev;
    cnt = 0;
    prev = 1'b0;
    eng_ready_i = 1'b0;
    eng_val_i = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_ready_i = 1'b0;
      if (eng_start_o) begin
        if (!prev) cnt = 0;
        else cnt++;
        if (cnt == 0 && eng_stale) begin
          eng_ready_i = 1'b1;
          eng_val_i   = 16'hDEAD;
        end
        if (cnt == eng_lat && !eng_hang) begin
          eng_ready_i = 1'b1;
          eng_val_i   = val_of(eng_addr_o);
        end
      end
      prev = eng_start_o;
    end
  end

  // Monitor: checks every busy cycle against the head of the scoreboard and pops on done.
  initial begin
    int cyc;
    int low;
    bit pb;
    bit ps;
    bit seen;
    cyc = 0; low = 0; pb = 1'b0; ps = 1'b0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; low = 0; pb = 1'b0; ps = 1'b0; seen = 1'b0;
      end else begin
        if (eng_start_o && !ps) begin
          if (seen) chk("start_gap_ge2", 32'(low >= 2), 32'd1);
          seen = 1'b1;
        end
        low = eng_start_o ? 0 : low + 1;
        ps  = eng_start_o;
        if (busy_o) begin
          cyc = pb ? cyc + 1 : 1;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_busy: grant %0d with no job queued", grant_idx_o);
          end else begin
            mon_e = sb[0];
            chk("grant_idx", 32'(grant_idx_o), mon_e.idx);
            chk("eng_addr", 32'(eng_addr_o), mon_e.addr);
            chk("eng_len", 32'(eng_len_o), mon_e.len);
            chk("eng_start", 32'(eng_start_o), 32'((mon_e.len != 0) && (done_o == '0)));
            if (done_o != '0) begin
              chk("done_vec", 32'(done_o), 32'(1) << mon_e.idx);
              chk("result", 32'(result_o), 32'(mon_e.res));
              chk("err", 32'(err_o), 32'(mon_e.err));
              chk("done_cycle", cyc, mon_e.cyc);
              void'(sb.pop_front());
            end else begin
              chk("err_no_done", 32'(err_o), 32'd0);
            end
          end
        end else begin
          chk("idle_no_done", {27'd0, err_o, done_o}, 32'd0);
        end
        pb = busy_o;
      end
    end
  end

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b0; req_i = '0; req_addr_i = '0; req_len_i = '0;
    eng_lat = 3; eng_hang = 1'b0; eng_stale = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(eng_start_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Contention: all four held, lat 3 -> done in busy cycle 5, order 0,1,2,3.
    set_slot(0, 100, 10); set_slot(1, 200, 20); set_slot(2, 300, 30); set_slot(3, 400, 40);
    push_exp(0, 100, 10, 16'h1234, 1'b0, 5);
    push_exp(1, 200, 20, 16'hBEEF, 1'b0, 5);
    push_exp(2, 300, 30, 16'h0F0F, 1'b0, 5);
    push_exp(3, 400, 40, 16'hCAFE, 1'b0, 5);
    run_jobs(4'b1111);

    // Single request with a stale ready in the first busy cycle; lat 10 -> cycle 12.
    set_slot(0, 14, 20);
    eng_lat = 10; eng_stale = 1'b1;
    push_exp(0, 14, 20, 16'hB1E6, 1'b0, 12);
    run_jobs(4'b0001);
    eng_stale = 1'b0; eng_lat = 3;

    // Round-robin wrap: serve 2, then 0 and 2 together -> 0 first.
    set_slot(0, 100, 10);
    push_exp(2, 300, 30, 16'h0F0F, 1'b0, 5);
    run_jobs(4'b0100);
    push_exp(0, 100, 10, 16'h1234, 1'b0, 5);
    push_exp(2, 300, 30, 16'h0F0F, 1'b0, 5);
    run_jobs(4'b0101);

    // Zero length on requester 1: no start, done in busy cycle 2, result FFFF.
    set_slot(1, 200, 0);
    push_exp(1, 200, 0, 16'hFFFF, 1'b0, 2);
    run_jobs(4'b0010);

    // Timeout: engine never ready -> done+err in busy cycle 17, result 0.
    eng_hang = 1'b1;
    push_exp(3, 400, 40, 16'h0000, 1'b1, 17);
    run_jobs(4'b1000);
    eng_hang = 1'b0;

    // Next job after timeout is served normally; result then holds while idle.
    set_slot(0, 500, 8);
    eng_lat = 4;
    push_exp(0, 500, 8, 16'h5A5A, 1'b0, 6);
    run_jobs(4'b0001);
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(result_o), 32'h5A5A);

    // Reset mid-job on requester 0, which leaves the pointer at 0 before the reset.
    set_slot(0, 600, 12);
    eng_hang = 1'b1;
    push_exp(0, 600, 12, 16'h0000, 1'b0, 0);
    req_i = 4'b0001;
    n = 0;
    while (!busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_job_granted", 32'(busy_o), 32'd1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    req_i = '0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_start", 32'(eng_start_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_addr", 32'(eng_addr_o), 32'd0);
    chk("midrst_len", 32'(eng_len_o), 32'd0);
    chk("midrst_grant", 32'(grant_idx_o), 32'd0);
    chk("midrst_done_err", {27'd0, err_o, done_o}, 32'd0);
    void'(sb.pop_front());
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    eng_hang = 1'b0; eng_lat = 2;

    // After release the pointer is back at NUM_REQ-1, so 0 beats 3.
    set_slot(0, 700, 4); set_slot(3, 800, 6);
    push_exp(0, 700, 4, 16'h1357, 1'b0, 4);
    push_exp(3, 800, 6, 16'h2468, 1'b0, 4);
    run_jobs(4'b1001);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
